// File: rtl/integral_image_cache_loader_mc.sv
// integral_image_cache_loader_mc: turns a raster word stream into registered
// integral-image cache writes with X/Y addressing for any NUM_COLS x NUM_ROWS frame.
// Ports: clk, reset (sync, active-high), start (arm/restart), data/data_ready in,
//   data_wanted out, we/wdata/waddrX/waddrY cache write port, loaded (sticky), busy.
// Optional feature: define INTEGRAL_ACCUM_EN to accumulate the integral image
//   from raw pixels on the fly (adds a NUM_COLS x WORD_SIZE line buffer).
module integral_image_cache_loader_mc #(
    parameter int WORD_SIZE = 32,
    parameter int PIX_WIDTH = 8,
    parameter int COL_WIDTH = 9,
    parameter int ROW_WIDTH = 8,
    parameter int NUM_COLS  = 320,
    parameter int NUM_ROWS  = 240
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 data_ready,
    output logic                 data_wanted,
    output logic                 we,
    output logic [WORD_SIZE-1:0] wdata,
    output logic [COL_WIDTH-1:0] waddrX,
    output logic [ROW_WIDTH-1:0] waddrY,
    output logic                 loaded,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    localparam logic [COL_WIDTH-1:0] X_LAST = COL_WIDTH'(NUM_COLS - 1);
    localparam logic [ROW_WIDTH-1:0] Y_LAST = ROW_WIDTH'(NUM_ROWS - 1);

    state_t               state;
    logic [COL_WIDTH-1:0] x;
    logic [ROW_WIDTH-1:0] y;
    logic                 accept;
    logic                 take;
    logic [WORD_SIZE-1:0] beat_word;

    assign data_wanted = (state == FILL);
    assign busy        = (state == FILL);
    assign loaded      = (state == DONE);

    assign accept = data_ready && data_wanted;
    // A beat arriving together with start belongs to the abandoned frame.
    assign take   = accept && !start;

`ifdef INTEGRAL_ACCUM_EN
    localparam int IW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    logic [WORD_SIZE-1:0] line_buf [NUM_COLS];
    logic [WORD_SIZE-1:0] row_sum;
    logic [WORD_SIZE-1:0] pix;
    logic [WORD_SIZE-1:0] sum_next;
    logic [WORD_SIZE-1:0] above;
    logic [IW-1:0]        xi;
    logic                 unused_data;

    assign xi          = x[IW-1:0];
    assign pix         = WORD_SIZE'(data[PIX_WIDTH-1:0]);
    assign unused_data = ^data;
    assign sum_next    = ((x == '0) ? '0 : row_sum) + pix;
    // Row 0 has nothing above it, so stale line-buffer contents never leak
    // into a restarted frame.
    assign above       = (y == '0) ? '0 : line_buf[xi];
    assign beat_word   = sum_next + above;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            row_sum <= '0;
        end else if (take) begin
            row_sum <= sum_next;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            line_buf[xi] <= beat_word;
        end
    end
`else
    assign beat_word = data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            we     <= 1'b0;
            wdata  <= '0;
            waddrX <= '0;
            waddrY <= '0;
        end else begin
            we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                FILL: begin
                    if (start) begin
                        x <= '0;
                        y <= '0;
                    end else if (accept) begin
                        we     <= 1'b1;
                        wdata  <= beat_word;
                        waddrX <= x;
                        waddrY <= y;
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y     <= '0;
                                state <= DONE;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= FILL;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integral_image_cache_loader_mc.sv
// tb_integral_image_cache_loader_mc: directed bench for the cache loader
// on a 4 x 3 frame, with hand-computed expected writes.
module tb_integral_image_cache_loader_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data = '0;
    logic        data_ready = 1'b0;
    logic        data_wanted;
    logic        we;
    logic [31:0] wdata;
    logic [8:0]  waddrX;
    logic [7:0]  waddrY;
    logic        loaded;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_d [64];
    int          log_x [64];
    int          log_y [64];
    int          wn = 0;

    int exp_ones [12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
    int exp_ramp [12] = '{0, 1, 3, 6, 4, 10, 18, 28, 12, 27, 45, 66};

    integral_image_cache_loader_mc #(
        .WORD_SIZE(32),
        .PIX_WIDTH(8),
        .COL_WIDTH(9),
        .ROW_WIDTH(8),
        .NUM_COLS (4),
        .NUM_ROWS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data       (data),
        .data_ready (data_ready),
        .data_wanted(data_wanted),
        .we         (we),
        .wdata      (wdata),
        .waddrX     (waddrX),
        .waddrY     (waddrY),
        .loaded     (loaded),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we && wn < 64) begin
            log_d[wn] = wdata;
            log_x[wn] = int'(waddrX);
            log_y[wn] = int'(waddrY);
            wn = wn + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1ns after the clock edge.
    task automatic cyc(input logic s, input logic r, input logic [31:0] d);
        start      = s;
        data_ready = r;
        data       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. reset, then idle without start
        #1;
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 32'd5);
            chk("idle_wanted", 32'(data_wanted), 32'd0);
        end
        chk("idle_we", 32'(we), 32'd0);
        chk("idle_wdata", wdata, 32'd0);
        chk("idle_x", 32'(waddrX), 32'd0);
        chk("idle_y", 32'(waddrY), 32'd0);
        chk("idle_loaded", 32'(loaded), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_nowrite", 32'(wn), 32'd0);

        // 2. full-rate frame 1..12
        cyc(1'b1, 1'b0, 32'd0);
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_wanted", 32'(data_wanted), 32'd1);
        wn = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1'b0, 1'b1, 32'(k));
            chk("full_we", 32'(we), 32'd1);
            if (k < 12) begin
                chk("full_wanted", 32'(data_wanted), 32'd1);
                chk("full_loaded", 32'(loaded), 32'd0);
            end
        end
        chk("last_loaded", 32'(loaded), 32'd1);
        chk("last_wanted", 32'(data_wanted), 32'd0);
        chk("last_x", 32'(waddrX), 32'd3);
        chk("last_y", 32'(waddrY), 32'd2);
        cyc(1'b0, 1'b1, 32'd77);
        chk("done_we", 32'(we), 32'd0);
        chk("done_loaded", 32'(loaded), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_hold_x", 32'(waddrX), 32'd3);
        chk("full_count", 32'(wn), 32'd12);
        for (int k = 1; k <= 12; k++) begin
`ifndef INTEGRAL_ACCUM_EN
            chk("full_data", log_d[k-1], 32'(k));
`endif
            chk("full_ax", 32'(log_x[k-1]), 32'((k - 1) % 4));
            chk("full_ay", 32'(log_y[k-1]), 32'((k - 1) / 4));
        end

        // 3. backpressure, data_ready alternating
        cyc(1'b1, 1'b0, 32'd0);
        chk("rearm_loaded", 32'(loaded), 32'd0);
        wn = 0;
        begin
            int k;
            k = 1;
            for (int i = 0; i < 24; i++) begin
                if (i % 2 == 0) begin
                    cyc(1'b0, 1'b1, 32'(k));
                    k++;
                end else begin
                    cyc(1'b0, 1'b0, 32'd0);
                    chk("bp_gap_we", 32'(we), 32'd0);
                end
            end
        end
        chk("bp_count", 32'(wn), 32'd12);
        chk("bp_loaded", 32'(loaded), 32'd1);
        for (int k = 1; k <= 12; k++) begin
`ifndef INTEGRAL_ACCUM_EN
            chk("bp_data", log_d[k-1], 32'(k));
`endif
            chk("bp_ax", 32'(log_x[k-1]), 32'((k - 1) % 4));
            chk("bp_ay", 32'(log_y[k-1]), 32'((k - 1) / 4));
        end

        // 4. restart mid-frame with a colliding beat
        cyc(1'b1, 1'b0, 32'd0);
        wn = 0;
        for (int k = 1; k <= 5; k++) cyc(1'b0, 1'b1, 32'(k));
        chk("rs_b5_we", 32'(we), 32'd1);
        chk("rs_b5_x", 32'(waddrX), 32'd0);
        chk("rs_b5_y", 32'(waddrY), 32'd1);
        cyc(1'b1, 1'b1, 32'd99);
        chk("rs_drop_we", 32'(we), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        cyc(1'b0, 1'b1, 32'd7);
        chk("rs_we", 32'(we), 32'd1);
        chk("rs_wdata", wdata, 32'd7);
        chk("rs_x", 32'(waddrX), 32'd0);
        chk("rs_y", 32'(waddrY), 32'd0);
        chk("rs_loaded", 32'(loaded), 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        chk("rs_count", 32'(wn), 32'd6);

        // 6. reset after 6 accepts, then refill
        cyc(1'b1, 1'b0, 32'd0);
        wn = 0;
        for (int k = 1; k <= 6; k++) cyc(1'b0, 1'b1, 32'(20 + k));
        chk("pre_rst_x", 32'(waddrX), 32'd1);
        chk("pre_rst_y", 32'(waddrY), 32'd1);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 32'd0);
        chk("mid_rst_count", 32'(wn), 32'd6);
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wanted", 32'(data_wanted), 32'd0);
        chk("mid_rst_wdata", wdata, 32'd0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 32'd55);
        chk("refill_we", 32'(we), 32'd1);
        chk("refill_wdata", wdata, 32'd55);
        chk("refill_x", 32'(waddrX), 32'd0);
        chk("refill_y", 32'(waddrY), 32'd0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 32'd56);
        chk("rst_drop_we", 32'(we), 32'd0);
        chk("rst_drop_x", 32'(waddrX), 32'd0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);

`ifdef INTEGRAL_ACCUM_EN
        // 5. accumulate mode
        cyc(1'b1, 1'b0, 32'd0);
        wn = 0;
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 32'hFFFF_FF01);
        cyc(1'b0, 1'b0, 32'd0);
        chk("acc1_count", 32'(wn), 32'd12);
        for (int k = 0; k < 12; k++)
            chk("acc1_data", log_d[k], 32'(exp_ones[k]));
        cyc(1'b1, 1'b0, 32'd0);
        wn = 0;
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 32'(k));
        chk("acc2_final", wdata, 32'd66);
        cyc(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 12; k++)
            chk("acc2_data", log_d[k], 32'(exp_ramp[k]));
`else
        chk("tbl_ones", 32'(exp_ones[11] + exp_ramp[0]), 32'(wn * 0 + 12));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
